// File: rtl/uart_baud_pkg.sv
// rtl/uart_baud_pkg.sv - baud code table and divisor helpers for uart_baud_timer
package uart_baud_pkg;

  typedef enum logic [3:0] {
    BAUD_300    = 4'd0,
    BAUD_600    = 4'd1,
    BAUD_1200   = 4'd2,
    BAUD_2400   = 4'd3,
    BAUD_4800   = 4'd4,
    BAUD_9600   = 4'd5,
    BAUD_14400  = 4'd6,
    BAUD_19200  = 4'd7,
    BAUD_38400  = 4'd8,
    BAUD_57600  = 4'd9,
    BAUD_115200 = 4'd10,
    BAUD_230400 = 4'd11,
    BAUD_460800 = 4'd12,
    BAUD_921600 = 4'd13
  } baud_code_e;

  localparam int NUM_CODES = 14;

  localparam int unsigned BAUD_TABLE [0:NUM_CODES-1] = '{
    300, 600, 1200, 2400, 4800, 9600, 14400,
    19200, 38400, 57600, 115200, 230400, 460800, 921600
  };

  // Codes 14 and 15 have no table entry.
  localparam logic [15:0] CODE_VALID = 16'h3FFF;

  function automatic logic [63:0] sdiv_f(input logic [63:0] clk,
                                         input logic [63:0] baud,
                                         input logic [63:0] os);
    logic [63:0] den;
    logic [63:0] q;
    den = baud * os;
    q   = (clk + (den >> 1)) / den;
    return (q == 64'd0) ? 64'd1 : q;
  endfunction

  function automatic logic [31:0] inc_f(input logic [63:0] clk,
                                        input logic [63:0] baud,
                                        input logic [63:0] os);
    logic [63:0] q;
    q = (((baud * os) << 32) + (clk >> 1)) / clk;
    return (q > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

endpackage

// File: rtl/uart_baud_rom.sv
// rtl/uart_baud_rom.sv - latched baud code to sample divisor (or phase increment
// when FRAC_DIV_EN is defined); purely combinational
module uart_baud_rom
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 1_843_200,
  parameter int          OVERSAMPLE  = 16,
  parameter int          DIV_W       = 20
) (
  input  logic [3:0]       i_code,
`ifdef FRAC_DIV_EN
  output logic [31:0]      o_inc
`else
  output logic [DIV_W-1:0] o_sdiv
`endif
);

`ifdef FRAC_DIV_EN
  logic [31:0] w_inc_tab [0:15];

  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g < NUM_CODES) begin : g_valid
      assign w_inc_tab[g] = inc_f(64'(CLK_FREQ_HZ), 64'(BAUD_TABLE[g]), 64'(OVERSAMPLE));
    end else begin : g_bad
      assign w_inc_tab[g] = 32'd0;
    end
  end

  assign o_inc = w_inc_tab[i_code];
`else
  logic [DIV_W-1:0] w_sdiv_tab [0:15];

  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g < NUM_CODES) begin : g_valid
      assign w_sdiv_tab[g] = DIV_W'(sdiv_f(64'(CLK_FREQ_HZ), 64'(BAUD_TABLE[g]), 64'(OVERSAMPLE)));
    end else begin : g_bad
      assign w_sdiv_tab[g] = DIV_W'(1);
    end
  end

  assign o_sdiv = w_sdiv_tab[i_code];
`endif

endmodule

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - UART oversample/bit-shift timer with frame bit counter;
// FRAC_DIV_EN selects a 32-bit phase accumulator instead of the integer divider
module uart_baud_timer
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 1_843_200,
  parameter int          OVERSAMPLE  = 16,
  parameter int          FRAME_BITS  = 11,
  parameter int          DIV_W       = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_baud_select,
  input  logic       i_shifting,
  input  logic       i_align,
  output logic       o_sample,
  output logic       o_shift,
  output logic [3:0] o_bit_idx,
  output logic       o_frame_done,
  output logic       o_bad_select
);

  localparam int              SCNT_W    = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2);
  localparam logic [3:0]      BIT_LAST  = 4'(FRAME_BITS - 1);

  logic              r_hold;
  logic              r_active;
  logic              r_bad;
  logic [3:0]        r_code;
  logic [SCNT_W-1:0] r_scnt;
  logic [3:0]        r_bit_idx;
  logic              r_sample;
  logic              r_shift;
  logic              r_frame_done;
  logic              w_run;
  logic              w_tick;

  assign w_run = i_shifting && r_active && !r_bad && !i_align;

`ifdef FRAC_DIV_EN
  logic [31:0] w_inc;
  logic [31:0] r_acc;
  logic [32:0] w_acc_sum;

  uart_baud_rom #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .OVERSAMPLE(OVERSAMPLE), .DIV_W(DIV_W)) u_rom (
    .i_code (r_code),
    .o_inc  (w_inc)
  );

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_inc};
  assign w_tick    = w_run && w_acc_sum[32];

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_run) r_acc <= '0;
    else                 r_acc <= w_acc_sum[31:0];
  end
`else
  logic [DIV_W-1:0] w_sdiv;
  logic [DIV_W-1:0] r_div;

  uart_baud_rom #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .OVERSAMPLE(OVERSAMPLE), .DIV_W(DIV_W)) u_rom (
    .i_code (r_code),
    .o_sdiv (w_sdiv)
  );

  assign w_tick = w_run && (r_div == w_sdiv - DIV_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_run || w_tick) r_div <= '0;
    else                           r_div <= r_div + DIV_W'(1);
  end
`endif

  // r_hold blocks re-latching after a mid-frame reset until shifting drops.
  always_ff @(posedge i_clk) begin
    r_sample     <= 1'b0;
    r_shift      <= 1'b0;
    r_frame_done <= 1'b0;
    if (i_rst || !i_shifting) begin
      r_hold    <= i_rst && i_shifting;
      r_active  <= 1'b0;
      r_bad     <= 1'b0;
      r_code    <= 4'd0;
      r_scnt    <= '0;
      r_bit_idx <= 4'd0;
    end else if (!r_active) begin
      if (!r_hold) begin
        r_active <= 1'b1;
        r_code   <= i_baud_select;
        r_bad    <= !CODE_VALID[i_baud_select];
      end
    end else if (i_align && !r_bad) begin
      r_scnt    <= SCNT_HALF;
      r_bit_idx <= 4'd0;
    end else if (w_tick) begin
      r_sample <= 1'b1;
      if (r_scnt == SCNT_LAST) begin
        r_scnt  <= '0;
        r_shift <= 1'b1;
        if (r_bit_idx == BIT_LAST) begin
          r_bit_idx    <= 4'd0;
          r_frame_done <= 1'b1;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
        end
      end else begin
        r_scnt <= r_scnt + SCNT_W'(1);
      end
    end
  end

  assign o_sample     = r_sample;
  assign o_shift      = r_shift;
  assign o_bit_idx    = r_bit_idx;
  assign o_frame_done = r_frame_done;
  assign o_bad_select = r_bad;

endmodule
